// File: rtl/qnigma_mdio_pkg.sv
// Shared MDIO register map, bit positions and PHY-emulator types.
package qnigma_mdio_pkg;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 5;

    localparam logic [AW-1:0] ADDR_BMCR   = 5'd0;
    localparam logic [AW-1:0] ADDR_BMSR   = 5'd1;
    localparam logic [AW-1:0] ADDR_PHYID1 = 5'd2;
    localparam logic [AW-1:0] ADDR_PHYID2 = 5'd3;
    localparam logic [AW-1:0] ADDR_ANAR   = 5'd4;
    localparam logic [AW-1:0] ADDR_ANLPAR = 5'd5;
    localparam logic [AW-1:0] ADDR_ANER   = 5'd6;
    localparam logic [AW-1:0] ADDR_GBCR   = 5'd9;
    localparam logic [AW-1:0] ADDR_GBSR   = 5'd10;

    localparam int unsigned BMCR_RESET_BIT   = 15;
    localparam int unsigned BMCR_ANE_BIT     = 12;
    localparam int unsigned BMCR_RESTART_BIT = 9;
    localparam int unsigned BMSR_AN_DONE_BIT = 5;
    localparam int unsigned BMSR_LINK_BIT    = 2;

    localparam logic [DW-1:0] BMCR_RST     = 16'h1140;
    localparam logic [DW-1:0] ANAR_RST_DEF = 16'h01E1;
    localparam logic [DW-1:0] GBSR_AN_VAL  = 16'h0C00;
    // Self-clearing BMCR bits are never stored; they are synthesised on read.
    localparam logic [DW-1:0] BMCR_SC_MASK = 16'h8200;

    typedef enum logic [1:0] {S_RESET, S_LINKDN, S_AN, S_UP} phy_emu_st_t;

    typedef struct packed {
        logic [DW-1:0] bmcr;
        logic [DW-1:0] bmsr;
        logic [DW-1:0] anar;
        logic [DW-1:0] anlpar;
        logic [DW-1:0] gbcr;
        logic          an_complete;
    } phy_emu_regs_t;

    function automatic logic is_ro(input logic [AW-1:0] a);
        return a inside {ADDR_BMSR, ADDR_PHYID1, ADDR_PHYID2, ADDR_ANLPAR, ADDR_ANER, ADDR_GBSR};
    endfunction

endpackage

// File: rtl/qnigma_mdio_phy_emu_inst.sv
// One emulated PHY: writable registers, soft reset, autonegotiation FSM and latch-low link.
module qnigma_mdio_phy_emu_inst
    import qnigma_mdio_pkg::*;
#(
    parameter logic [DW-1:0] BMSR_CAP   = 16'h7909,
    parameter logic [DW-1:0] ANAR_RST   = ANAR_RST_DEF,
    parameter logic [DW-1:0] LP_ABILITY = 16'hC1E1,
    parameter int unsigned   RST_TICKS  = 16,
    parameter int unsigned   AN_TICKS   = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          rd_bmsr,
    input  logic          link,
    output phy_emu_regs_t regs_c,
    output logic          busy_c,
    output logic          an_done
);

    localparam int unsigned CNT_MAX = (RST_TICKS > AN_TICKS) ? RST_TICKS : AN_TICKS;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_TICKS - 1);
    localparam logic [CNT_W-1:0] AN_LAST  = CNT_W'(AN_TICKS - 1);

    phy_emu_st_t    st;
    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]  bmcr;
    logic [DW-1:0]  anar;
    logic [DW-1:0]  anlpar;
    logic [DW-1:0]  gbcr;
    logic           an_complete;
    logic           restart;
    logic           link_latch;

    logic wr_ok;
    logic wr_bmcr;
    logic soft_rst_req;
    logic restart_req;
    logic rst_exit;

    assign busy_c       = (st == S_RESET);
    assign wr_ok        = we && !busy_c;
    assign wr_bmcr      = wr_ok && (waddr == ADDR_BMCR);
    assign soft_rst_req = wr_bmcr && wdata[BMCR_RESET_BIT];
    // Restart only means something while a link partner is present to negotiate with.
    assign restart_req  = wr_bmcr && wdata[BMCR_RESTART_BIT] && wdata[BMCR_ANE_BIT]
                          && link && ((st == S_AN) || (st == S_UP));
    assign rst_exit     = busy_c && (cnt == RST_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st          <= S_LINKDN;
            cnt         <= '0;
            bmcr        <= BMCR_RST;
            anar        <= ANAR_RST;
            anlpar      <= '0;
            gbcr        <= '0;
            an_complete <= 1'b0;
            restart     <= 1'b0;
            an_done     <= 1'b0;
        end else if (busy_c) begin
            if (rst_exit) begin
                st     <= S_LINKDN;
                cnt    <= '0;
                bmcr   <= BMCR_RST;
                anar   <= ANAR_RST;
                anlpar <= '0;
                gbcr   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (soft_rst_req) begin
            st          <= S_RESET;
            cnt         <= '0;
            anlpar      <= '0;
            an_complete <= 1'b0;
            restart     <= 1'b0;
            an_done     <= 1'b0;
        end else begin
            if (wr_bmcr)
                bmcr <= wdata & ~BMCR_SC_MASK;
            if (wr_ok && (waddr == ADDR_ANAR))
                anar <= wdata;
            if (wr_ok && (waddr == ADDR_GBCR))
                gbcr <= wdata;

            if (!link) begin
                st          <= S_LINKDN;
                anlpar      <= '0;
                an_complete <= 1'b0;
                restart     <= 1'b0;
                an_done     <= 1'b0;
            end else if (restart_req) begin
                st          <= S_AN;
                cnt         <= '0;
                restart     <= 1'b1;
                an_complete <= 1'b0;
                an_done     <= 1'b0;
            end else begin
                case (st)
                    S_LINKDN: begin
                        cnt <= '0;
                        st  <= bmcr[BMCR_ANE_BIT] ? S_AN : S_UP;
                    end
                    S_AN: begin
                        if (cnt == AN_LAST) begin
                            st          <= S_UP;
                            anlpar      <= LP_ABILITY;
                            an_complete <= 1'b1;
                            restart     <= 1'b0;
                            an_done     <= bmcr[BMCR_ANE_BIT];
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_UP:    an_done <= an_complete && bmcr[BMCR_ANE_BIT];
                    default: st <= S_LINKDN;
                endcase
            end
        end
    end

    // Latch-low: only a BMSR read with the link present can re-arm the bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            link_latch <= 1'b0;
        else if (rst_exit || !link)
            link_latch <= 1'b0;
        else if (rd_bmsr)
            link_latch <= 1'b1;
    end

    always_comb begin
        regs_c             = '0;
        regs_c.bmcr        = bmcr | (DW'(busy_c) << BMCR_RESET_BIT) | (DW'(restart) << BMCR_RESTART_BIT);
        regs_c.bmsr        = BMSR_CAP | (DW'(an_complete) << BMSR_AN_DONE_BIT)
                                      | (DW'(link_latch) << BMSR_LINK_BIT);
        regs_c.anar        = anar;
        regs_c.anlpar      = anlpar;
        regs_c.gbcr        = gbcr;
        regs_c.an_complete = an_complete;
    end

endmodule

// File: rtl/qnigma_mdio_phy_emu_bank.sv
// Multi-PHY MDIO register bank: PHY address decode, read mux/register, hit and err reporting.
module qnigma_mdio_phy_emu_bank
    import qnigma_mdio_pkg::*;
#(
    parameter int unsigned   N_PHY      = 2,
    parameter logic [AW-1:0] ADDR_BASE  = 5'd1,
    parameter logic [DW-1:0] PHYID1     = 16'h001C,
    parameter logic [DW-1:0] PHYID2     = 16'hC916,
    parameter logic [DW-1:0] BMSR_CAP   = 16'h7909,
    parameter logic [DW-1:0] ANAR_RST   = ANAR_RST_DEF,
    parameter logic [DW-1:0] LP_ABILITY = 16'hC1E1,
    parameter int unsigned   RST_TICKS  = 16,
    parameter int unsigned   AN_TICKS   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    pin,
    input  logic [AW-1:0]    ain,
    input  logic [DW-1:0]    din,
    input  logic             vin,
    input  logic             rin,
    input  logic [N_PHY-1:0] link_in,
    output logic [DW-1:0]    dout,
    output logic             dv,
    output logic             hit,
    output logic             err,
    output logic [N_PHY-1:0] an_done
);

    logic [AW-1:0] idx;
    logic          match_c;
    phy_emu_regs_t regs_c [N_PHY];
    logic [N_PHY-1:0] busy_c;
    phy_emu_regs_t sel_regs_c;
    logic          sel_busy_c;
    logic [DW-1:0] rd_val_c;

    // Modulo-32 offset from the base address selects the instance.
    assign idx     = pin - ADDR_BASE;
    assign match_c = 32'(idx) < N_PHY;

    for (genvar k = 0; k < N_PHY; k++) begin : g_phy
        logic sel;
        assign sel = (idx == AW'(k));

        qnigma_mdio_phy_emu_inst #(
            .BMSR_CAP   (BMSR_CAP),
            .ANAR_RST   (ANAR_RST),
            .LP_ABILITY (LP_ABILITY),
            .RST_TICKS  (RST_TICKS),
            .AN_TICKS   (AN_TICKS)
        ) u_inst (
            .clk     (clk),
            .rst     (rst),
            .we      (vin && sel),
            .waddr   (ain),
            .wdata   (din),
            .rd_bmsr (rin && sel && (ain == ADDR_BMSR)),
            .link    (link_in[k]),
            .regs_c  (regs_c[k]),
            .busy_c  (busy_c[k]),
            .an_done (an_done[k])
        );
    end

    always_comb begin
        sel_regs_c = '0;
        sel_busy_c = 1'b0;
        rd_val_c   = '0;
        for (int unsigned k = 0; k < N_PHY; k++) begin
            if (idx == AW'(k)) begin
                sel_regs_c = regs_c[k];
                sel_busy_c = busy_c[k];
            end
        end
        case (ain)
            ADDR_BMCR:   rd_val_c = sel_regs_c.bmcr;
            ADDR_BMSR:   rd_val_c = sel_regs_c.bmsr;
            ADDR_PHYID1: rd_val_c = PHYID1;
            ADDR_PHYID2: rd_val_c = PHYID2;
            ADDR_ANAR:   rd_val_c = sel_regs_c.anar;
            ADDR_ANLPAR: rd_val_c = sel_regs_c.anlpar;
            ADDR_ANER:   rd_val_c = DW'(sel_regs_c.an_complete);
            ADDR_GBCR:   rd_val_c = sel_regs_c.gbcr;
            ADDR_GBSR:   rd_val_c = sel_regs_c.an_complete ? GBSR_AN_VAL : '0;
            default:     rd_val_c = '0;
        endcase
    end

    // Unmatched reads float high; writes to a busy instance are dropped silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= '0;
            dv   <= 1'b0;
            hit  <= 1'b0;
            err  <= 1'b0;
        end else begin
            dv  <= rin;
            hit <= match_c && (vin || rin);
            err <= ((vin || rin) && !match_c)
                   || (vin && match_c && is_ro(ain) && !sel_busy_c);
            if (rin)
                dout <= match_c ? rd_val_c : 16'hFFFF;
        end
    end

endmodule

// File: tb/tb_qnigma_mdio_phy_emu_bank.sv
// Scoreboard bench for the MDIO PHY emulator bank with default parameters.
module tb_qnigma_mdio_phy_emu_bank;

    localparam int unsigned N_PHY     = 2;
    localparam int unsigned AN_TICKS  = 64;
    localparam int unsigned RST_TICKS = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       pin;
    logic [4:0]       ain;
    logic [15:0]      din;
    logic             vin;
    logic             rin;
    logic [N_PHY-1:0] link_in;
    logic [15:0]      dout;
    logic             dv;
    logic             hit;
    logic             err;
    logic [N_PHY-1:0] an_done;

    typedef struct {
        logic [15:0] d;
        logic        h;
        logic        e;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n;

    always #5 clk = ~clk;

    qnigma_mdio_phy_emu_bank dut (
        .clk     (clk),
        .rst     (rst),
        .pin     (pin),
        .ain     (ain),
        .din     (din),
        .vin     (vin),
        .rin     (rin),
        .link_in (link_in),
        .dout    (dout),
        .dv      (dv),
        .hit     (hit),
        .err     (err),
        .an_done (an_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Read strobe for one cycle; expected response queued for the monitor.
    task automatic rd(input logic [4:0] p, input logic [4:0] a, input logic [15:0] d, input logic h);
        sb.push_back('{d: d, h: h, e: !h});
        pin = p;
        ain = a;
        rin = 1'b1;
        @(negedge clk);
        rin = 1'b0;
        chk("rd_latency", 32'(sb.size()), 0);
    endtask

    task automatic wr(input logic [4:0] p, input logic [4:0] a, input logic [15:0] d);
        pin = p;
        ain = a;
        din = d;
        vin = 1'b1;
        @(negedge clk);
        vin = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (dv) begin
            if (sb.size() == 0) begin
                chk("dv_spurious", 32'(dv), 0);
            end else begin
                mon_e = sb.pop_front();
                chk("rd_dout", 32'(dout), 32'(mon_e.d));
                chk("rd_hit", 32'(hit), 32'(mon_e.h));
                chk("rd_err", 32'(err), 32'(mon_e.e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; pin = '0; ain = '0; din = '0; vin = 1'b0; rin = 1'b0; link_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_dv", 32'(dv), 0);
        chk("rst_hit", 32'(hit), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_an_done", 32'(an_done), 0);
        rst = 1'b1;
        @(negedge clk);

        rd(5'd1, 5'd0, 16'h1140, 1'b1);
        rd(5'd1, 5'd2, 16'h001C, 1'b1);
        rd(5'd2, 5'd3, 16'hC916, 1'b1);
        rd(5'd1, 5'd4, 16'h01E1, 1'b1);
        rd(5'd1, 5'd7, 16'h0000, 1'b1);
        rd(5'd1, 5'd10, 16'h0000, 1'b1);

        // Autonegotiation on PHY 0
        link_in[0] = 1'b1;
        repeat (AN_TICKS) @(negedge clk);
        chk("an_done_early", 32'(an_done[0]), 0);
        @(negedge clk);
        chk("an_done_set", 32'(an_done[0]), 1);
        chk("an_done_other", 32'(an_done[1]), 0);
        rd(5'd1, 5'd1, 16'h7929, 1'b1);
        rd(5'd1, 5'd1, 16'h792D, 1'b1);
        rd(5'd1, 5'd5, 16'hC1E1, 1'b1);
        rd(5'd1, 5'd6, 16'h0001, 1'b1);
        rd(5'd1, 5'd10, 16'h0C00, 1'b1);

        // One-cycle link drop
        link_in[0] = 1'b0;
        @(negedge clk);
        chk("an_done_drop", 32'(an_done[0]), 0);
        link_in[0] = 1'b1;
        rd(5'd1, 5'd1, 16'h7909, 1'b1);
        rd(5'd1, 5'd5, 16'h0000, 1'b1);
        n = 0;
        while (!an_done[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("an_relock", 32'(an_done[0]), 1);
        rd(5'd1, 5'd1, 16'h792D, 1'b1);

        // Write protection and unmatched PHYs
        wr(5'd1, 5'd1, 16'hFFFF);
        chk("err_ro", 32'(err), 1);
        chk("hit_wr", 32'(hit), 1);
        @(negedge clk);
        chk("err_pulse", 32'(err), 0);
        rd(5'd1, 5'd1, 16'h792D, 1'b1);
        rd(5'd9, 5'd0, 16'hFFFF, 1'b0);
        rd(5'd3, 5'd0, 16'hFFFF, 1'b0);
        rd(5'd0, 5'd2, 16'hFFFF, 1'b0);
        wr(5'd9, 5'd4, 16'h1234);
        chk("err_wr_nomatch", 32'(err), 1);
        chk("hit_wr_nomatch", 32'(hit), 0);
        wr(5'd1, 5'd7, 16'h1234);
        chk("err_wr_unmapped", 32'(err), 0);

        // Soft reset on PHY 1
        wr(5'd2, 5'd4, 16'h0061);
        rd(5'd2, 5'd4, 16'h0061, 1'b1);
        wr(5'd2, 5'd0, 16'h8000);
        chk("err_softrst", 32'(err), 0);
        for (int i = 0; i < int'(RST_TICKS); i++) begin
            if (i == 4) begin
                wr(5'd2, 5'd1, 16'hFFFF);
                chk("err_busy", 32'(err), 0);
            end else begin
                rd(5'd2, 5'd0, 16'h9140, 1'b1);
            end
        end
        rd(5'd2, 5'd4, 16'h01E1, 1'b1);
        rd(5'd2, 5'd0, 16'h1140, 1'b1);

        // Restart AN on PHY 0
        wr(5'd1, 5'd0, 16'h1340);
        chk("an_done_restart", 32'(an_done[0]), 0);
        rd(5'd1, 5'd0, 16'h1340, 1'b1);
        n = 1;
        while (!an_done[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("restart_len", 32'(n), AN_TICKS);
        rd(5'd1, 5'd0, 16'h1140, 1'b1);

        // Simultaneous read and write
        sb.push_back('{d: 16'h01E1, h: 1'b1, e: 1'b0});
        pin = 5'd1; ain = 5'd4; din = 16'h00AA; vin = 1'b1; rin = 1'b1;
        @(negedge clk);
        vin = 1'b0; rin = 1'b0;
        chk("rw_latency", 32'(sb.size()), 0);
        rd(5'd1, 5'd4, 16'h00AA, 1'b1);
        wr(5'd1, 5'd9, 16'h0300);
        rd(5'd1, 5'd9, 16'h0300, 1'b1);

        // Restart ignored with ane=0
        wr(5'd1, 5'd0, 16'h0200);
        rd(5'd1, 5'd0, 16'h0000, 1'b1);

        // Reset asserted while a read is pending
        pin = 5'd1; ain = 5'd0; rin = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        rin = 1'b0;
        chk("midrst_dv", 32'(dv), 0);
        chk("midrst_dout", 32'(dout), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("postrst_dv", 32'(dv), 0);
        rd(5'd1, 5'd0, 16'h1140, 1'b1);
        rd(5'd1, 5'd4, 16'h01E1, 1'b1);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
